// File: rtl/wb_stage_buffer.sv
// wb_stage_buffer
//   Two-entry elastic buffer between the MEM and WB stages. The main entry
//   drives the WB-facing outputs. The skid entry absorbs one extra transfer,
//   which lets in_ready come straight from a register with no combinational
//   path from out_ready.
//
// Ports
//   clk, reset          clock; synchronous active-high reset
//   flush               discard every buffered entry
//   in_valid/in_ready   upstream handshake (in_ready is registered)
//   ctrl_in, ra_in,     incoming entry fields
//   alu_in, mem_in, r0_in
//   out_valid/out_ready downstream handshake
//   ctrl_o, ra_o,       head entry fields; ctrl_o[1:0] read as 0 when no entry
//   alu_o, mem_o, r0_o
//   wb_data_o           writeback value: mem_o when ctrl_o[2], else alu_o
//
// Optional feature (macro WB_STAGE_FWD_EN)
//   fwd_valid, fwd_addr, fwd_data   forwarding view of the head entry,
//                                   zero while the buffer is empty
module wb_stage_buffer #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4,
  parameter int CTRL_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] ctrl_in,
  input  logic [ADDR_W-1:0] ra_in,
  input  logic [DATA_W-1:0] alu_in,
  input  logic [DATA_W-1:0] mem_in,
  input  logic [DATA_W-1:0] r0_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [ADDR_W-1:0] ra_o,
  output logic [DATA_W-1:0] alu_o,
  output logic [DATA_W-1:0] mem_o,
  output logic [DATA_W-1:0] r0_o,
  output logic [DATA_W-1:0] wb_data_o
`ifdef WB_STAGE_FWD_EN
  ,
  output logic              fwd_valid,
  output logic [ADDR_W-1:0] fwd_addr,
  output logic [DATA_W-1:0] fwd_data
`endif
);

  typedef enum logic [1:0] {
    S_EMPTY,
    S_ONE,
    S_FULL
  } state_t;

  state_t state, state_next;

  logic [CTRL_W-1:0] main_ctrl, skid_ctrl;
  logic [ADDR_W-1:0] main_ra,   skid_ra;
  logic [DATA_W-1:0] main_alu,  skid_alu;
  logic [DATA_W-1:0] main_mem,  skid_mem;
  logic [DATA_W-1:0] main_r0,   skid_r0;

  logic take_in, take_out;
  logic load_main_in, load_main_skid, load_skid;

  assign out_valid = (state != S_EMPTY);
  assign take_in   = in_valid && in_ready;
  assign take_out  = out_valid && out_ready;

  always_comb begin
    state_next     = state;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    if (flush) begin
      state_next = S_EMPTY;
    end else begin
      case (state)
        S_EMPTY: begin
          if (take_in) begin
            state_next   = S_ONE;
            load_main_in = 1'b1;
          end
        end
        S_ONE: begin
          if (take_in && take_out) begin
            load_main_in = 1'b1;
          end else if (take_in) begin
            state_next = S_FULL;
            load_skid  = 1'b1;
          end else if (take_out) begin
            state_next = S_EMPTY;
          end
        end
        S_FULL: begin
          if (take_out) begin
            state_next     = S_ONE;
            load_main_skid = 1'b1;
          end
        end
        default: state_next = S_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_EMPTY;
      in_ready  <= 1'b1;
      main_ctrl <= '0;
      main_ra   <= '0;
      main_alu  <= '0;
      main_mem  <= '0;
      main_r0   <= '0;
      skid_ctrl <= '0;
      skid_ra   <= '0;
      skid_alu  <= '0;
      skid_mem  <= '0;
      skid_r0   <= '0;
    end else begin
      state    <= state_next;
      // registered copy of "not FULL" keeps out_ready off the in_ready path
      in_ready <= (state_next != S_FULL);
      if (load_main_in) begin
        main_ctrl <= ctrl_in;
        main_ra   <= ra_in;
        main_alu  <= alu_in;
        main_mem  <= mem_in;
        main_r0   <= r0_in;
      end else if (load_main_skid) begin
        main_ctrl <= skid_ctrl;
        main_ra   <= skid_ra;
        main_alu  <= skid_alu;
        main_mem  <= skid_mem;
        main_r0   <= skid_r0;
      end
      if (load_skid) begin
        skid_ctrl <= ctrl_in;
        skid_ra   <= ra_in;
        skid_alu  <= alu_in;
        skid_mem  <= mem_in;
        skid_r0   <= r0_in;
      end
    end
  end

  // write-enable bits are masked when empty; memSource and upper bits hold
  always_comb begin
    ctrl_o        = main_ctrl;
    ctrl_o[1:0]   = main_ctrl[1:0] & {2{out_valid}};
  end

  assign ra_o      = main_ra;
  assign alu_o     = main_alu;
  assign mem_o     = main_mem;
  assign r0_o      = main_r0;
  assign wb_data_o = main_ctrl[2] ? main_mem : main_alu;

`ifdef WB_STAGE_FWD_EN
  always_comb begin
    fwd_valid = out_valid && main_ctrl[0];
    fwd_addr  = out_valid ? main_ra   : '0;
    fwd_data  = out_valid ? wb_data_o : '0;
  end
`endif

endmodule

// File: doc/wb_stage_buffer.md
WB_STAGE_BUFFER -- requirements
Module: wb_stage_buffer

Interface
REQ-001 Parameter DATA_W, default 16: width of the ALU result, memory data and R0 data paths.
REQ-002 Parameter ADDR_W, default 4: width of the destination register address.
REQ-003 Parameter CTRL_W, default 3: control bits; bit0 regWrite, bit1 r0Write, bit2 memSource, upper bits passed through.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset; sampled on rising edge of clk.
REQ-006 flush  input  1  discard all buffered entries.
REQ-007 in_valid  input  1  upstream (MEM) entry present.
REQ-008 in_ready  output  1  buffer can accept an entry; driven directly from a register.
REQ-009 ctrl_in  input  CTRL_W  control bits of the incoming entry.
REQ-010 ra_in  input  ADDR_W  destination register address.
REQ-011 alu_in / mem_in / r0_in  input  DATA_W each  ALU result, memory read data, R0 data.
REQ-012 out_valid  output  1  head entry valid toward WB.
REQ-013 out_ready  input  1  WB consumes the head entry.
REQ-014 ctrl_o, ra_o, alu_o, mem_o, r0_o  output  CTRL_W/ADDR_W/DATA_W  head entry fields.
REQ-015 wb_data_o  output  DATA_W  selected writeback value: mem_o if ctrl_o[2] else alu_o.

Function
REQ-016 Storage: two entries, main (drives outputs) and skid; states EMPTY, ONE, FULL.
REQ-017 Transfer in occurs when in_valid && in_ready; transfer out when out_valid && out_ready.
REQ-018 EMPTY: in -> ONE; entry written to main; out_valid asserted next cycle (1-cycle latency).
REQ-019 ONE: in and out together -> ONE, main replaced; in only -> FULL, entry written to skid; out only -> EMPTY.
REQ-020 FULL: out -> ONE, skid moves to main; no in possible since in_ready=0.
REQ-021 in_ready = 1 in EMPTY and ONE, 0 in FULL, registered so it has no combinational path from out_ready.
REQ-022 Entry order strictly FIFO; no entry dropped or duplicated except by flush/reset.
REQ-023 out_valid = 1 in ONE and FULL.
REQ-024 ctrl_o bits 0..1 forced to 0 whenever out_valid=0; data fields hold their last value.
REQ-025 flush: next state EMPTY, in_ready=1 next cycle; a same-cycle in transfer is discarded; flush overrides out_ready.
REQ-026 in_valid while in_ready=0 has no effect; upstream holds its entry.
REQ-027 wb_data_o purely combinational from main entry; no arithmetic, widths unchanged.

Reset
REQ-028 reset high at a clock edge -> state EMPTY; all outputs 0 except in_ready=1, from the following cycle.
REQ-029 reset takes priority over flush and any transfer; in-flight entries are lost.
REQ-030 reset held multiple cycles keeps outputs at reset values; first acceptance possible on the first edge after deassertion.

Configuration
REQ-031 Macro WB_STAGE_FWD_EN: when defined, adds outputs fwd_valid (1), fwd_addr (ADDR_W) and fwd_data (DATA_W).
REQ-032 With the macro: fwd_valid = out_valid && ctrl_o[0]; fwd_addr = ra_o; fwd_data = wb_data_o; these ports are zero under reset/flush.
REQ-033 Without the macro: the ports are absent and behaviour is otherwise identical.

Verification
REQ-034 Reset: reset=1 two cycles with in_valid=1 -> out_valid=0, ctrl_o=0, in_ready=1; first entry accepted after deassertion.
REQ-035 Streaming: out_ready=1, 8 back-to-back entries with alu_in=1..8 -> alu_o=1..8 on consecutive cycles, each one cycle after acceptance, in_ready constantly 1.
REQ-036 Backpressure: out_ready=0, push A=0x1111, B=0x2222 -> in_ready=0 after B; then out_ready=1 -> A then B in order; in_ready returns to 1.
REQ-037 Flush in FULL with simultaneous in_valid (C=0x3333) -> next cycle out_valid=0, in_ready=1, C never appears.
REQ-038 Writeback select: ctrl_in=3'b101, alu_in=0x00AA, mem_in=0x5500 -> wb_data_o=0x5500; ctrl_in=3'b001 -> wb_data_o=0x00AA.
REQ-039 With WB_STAGE_FWD_EN: ctrl_in=3'b001, ra_in=4'h7, alu_in=0x1234 -> fwd_valid=1, fwd_addr=7, fwd_data=0x1234; with ctrl_in[0]=0 -> fwd_valid=0.
